truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives an N-input combinational function-under-test (FUT) through all 2^N input vectors in ascending binary order.
- Holds each vector for a settle interval, then samples the FUT output into a truth-table register and compares the result against an expected mask.
- Replaces hand-written per-vector stimulus for lab combinational blocks. Sits between the bench or top level and any single-output combinational module.

Parameters:
- N_IN, 4, number of FUT inputs; vectors 0..2^N_IN-1.
- SETTLE, 2, extra hold cycles per vector before sampling (0..15). Each vector is held SETTLE+1 cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; honoured only in IDLE
- abort  in  1  stop the sweep and return to IDLE with no done pulse
- expected  in  2^N_IN  golden truth table; bit i = required f for vector i
- vec_out  out  N_IN  vector applied to FUT; MSB = first FUT input (a), LSB = last (d)
- f_in  in  1  FUT output
- busy  out  1  high while vectors are being applied
- done  out  1  one-cycle pulse when the sweep completes
- table_out  out  2^N_IN  captured truth table; bit i = f for vector i
- mismatch_cnt  out  N_IN+1  count of bits where table_out differs from expected
- pass  out  1  high when mismatch_cnt==0; valid from the done pulse onward

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; vec_out, busy, done, table_out, mismatch_cnt and pass all go to 0. Reset mid-sweep behaves identically.
- States:
  - IDLE -> APPLY when start=1.
  - APPLY: hold counter runs 0..SETTLE.
    - At the counter's last value, capture f_in into table_out[idx].
    - If idx<2^N_IN-1: increment idx and clear the counter.
    - Else: go to DONE.
  - DONE -> IDLE after exactly one cycle.
- Timing (cycle 0 = the edge where start is sampled in IDLE):
  - Cycles 1..2^N_IN*(SETTLE+1): busy=1.
  - Vector i is on vec_out during cycles 1+i*(SETTLE+1) through (i+1)*(SETTLE+1).
  - f_in is sampled on the final edge of that window.
  - Next cycle: done=1, busy=0. pass and mismatch_cnt are final in the same cycle as done.
  - Defaults (N_IN=4, SETTLE=2): 48 busy cycles, done in cycle 49.
- On accepted start: table_out and mismatch_cnt clear to 0; pass drops to 0.
- Compare: on each capture, mismatch_cnt increments when f_in != expected[idx]. Maximum count is 2^N_IN, which fits in N_IN+1 bits and cannot wrap.
- expected is sampled per vector at its capture edge. It must stay stable for the whole sweep.
- vec_out=0 whenever not busy.
- start while busy or in DONE: ignored, no restart.
- abort=1 while busy: next state is IDLE, busy=0, no done pulse, pass=0. Partial table_out and mismatch_cnt are retained. abort in IDLE or DONE is ignored. If rst and abort are both high, rst wins.
- start and abort both high in IDLE: start wins. abort has no effect outside busy.
- SETTLE=0: one cycle per vector, capture on every edge.
- After DONE, table_out, mismatch_cnt and pass hold until the next accepted start or rst.

Decomposition:
- Shared package `sweep_pkg`:
  - State encoding constants (IDLE, APPLY, DONE as a 2-bit localparam set).
  - Default N_IN and SETTLE values.
  - A function returning the sweep length 2^N_IN*(SETTLE+1), for benches.
- One sub-module, `settle_timer`: a loadable down-counter parameterised by SETTLE. It outputs `expire` on the capture cycle and is cleared by the top FSM on each vector advance.
- The top module holds the FSM, idx counter, capture register and compare logic.

Test Plan:
- Default parameters, FUT f=(a&b)|(c&~d), expected=16'hF444, pulse start -> vec_out steps 0..15, each held 3 cycles; done in cycle 49; table_out=16'hF444, mismatch_cnt=0, pass=1.
- Same FUT, expected=16'hF445 -> table_out=16'hF444, mismatch_cnt=1, pass=0.
- FUT stuck at 1, expected=16'h0000 -> mismatch_cnt=16 (5'b10000), pass=0, no wrap.
- SETTLE=0, FUT f=a^b^c^d, expected=16'h6996 -> busy for 16 cycles, done in cycle 17, pass=1. start re-pulsed during busy has no effect on timing.
- rst asserted in cycle 20 of a default sweep -> next cycle all outputs 0 and state IDLE. A fresh start then completes normally in 49 cycles.
- abort in cycle 10 (vector 3) -> busy falls next cycle, no done pulse, table_out holds bits 0..2 only, pass=0. A subsequent start clears table_out and sweeps fully.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, default
// sizing and a helper giving the number of busy cycles in one sweep.
package sweep_pkg;

   localparam int DEF_N_IN   = 4;
   localparam int DEF_SETTLE = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_APPLY = ST_APPLY,
      S_DONE  = ST_DONE
   } sweep_state_t;

   // Busy cycles for one full sweep: every vector is held settle+1 cycles.
   function automatic int sweep_len(input int n_in, input int settle);
      return (2 ** n_in) * (settle + 1);
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-vector hold timer. Sits at SETTLE while loaded, counts down while the
// sweep runs, and flags expire in the cycle where the FUT output is captured.
module settle_timer
   import sweep_pkg::*;
#(
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_run,
   output logic o_expire
);

   localparam logic [3:0] LOAD_VAL = 4'(SETTLE);

   logic [3:0] r_cnt;

   // Reload on every vector advance (and whenever idle), otherwise count down to zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= LOAD_VAL;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (i_run && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign o_expire = i_run && (r_cnt == 4'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks an N_IN-input combinational block through all
// input vectors in ascending order, captures its output per vector and
// compares the captured table against a golden mask.
//
// state | meaning
// IDLE  | waiting for start; vec_out parked at 0, results held
// APPLY | vector idx driven, settle timer running, capture on expire
// DONE  | one-cycle done pulse, pass/mismatch_cnt final
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int N_IN   = DEF_N_IN,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [2**N_IN-1:0]   i_expected,
   output logic [N_IN-1:0]      o_vec_out,
   input  logic                 i_f_in,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2**N_IN-1:0]   o_table_out,
   output logic [N_IN:0]        o_mismatch_cnt,
   output logic                 o_pass
);

   localparam int N_VEC = 2 ** N_IN;

   sweep_state_t       r_state;
   logic [N_IN-1:0]    r_idx;
   logic [N_VEC-1:0]   r_table;
   logic [N_IN:0]      r_mis;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;

   logic               w_run;
   logic               w_expire;
   logic               w_timer_load;
   logic               w_last;
   logic               w_diff;
   logic [N_IN:0]      w_mis_next;

   assign w_run        = (r_state == S_APPLY);
   assign w_timer_load = !w_run || w_expire;
   assign w_last       = &r_idx;
   assign w_diff       = i_f_in ^ i_expected[r_idx];
   assign w_mis_next   = r_mis + {{N_IN{1'b0}}, w_diff};

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (w_timer_load),
      .i_run    (w_run),
      .o_expire (w_expire)
   );

   // Sweep sequencing, per-vector capture and running mismatch count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_table <= '0;
         r_mis   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_APPLY;
                  r_busy  <= 1'b1;
                  r_idx   <= '0;
                  r_table <= '0;
                  r_mis   <= '0;
                  r_pass  <= 1'b0;
               end
            end
            S_APPLY: begin
               if (i_abort) begin
                  // Partial results stay visible; pass remains low.
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_idx   <= '0;
               end else if (w_expire) begin
                  r_table[r_idx] <= i_f_in;
                  r_mis          <= w_mis_next;
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_idx   <= '0;
                     r_pass  <= (w_mis_next == '0);
                  end else begin
                     r_idx <= r_idx + N_IN'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_vec_out      = r_idx;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_table_out    = r_table;
   assign o_mismatch_cnt = r_mis;
   assign o_pass         = r_pass;

endmodule
